// File: rtl/ddr2_pkg.sv
// Shared types and constants for the DDR2 responder: FSM states, MIG command codes, line geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr2_pkg;

  localparam int LINE_W = 128;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;
  localparam int MASK_W = LINE_W / 8;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/ddr2_lane_mux.sv
// Maps a 32-bit word onto a 128-bit MIG line: replicated write data, byte mask, and read-lane select.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module ddr2_lane_mux
  import ddr2_pkg::*;
(
  input  logic [1:0]        lane_i,
  input  logic [WORD_W-1:0] wd_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] wdf_data_o,
  output logic [MASK_W-1:0] wdf_mask_o,
  output logic [WORD_W-1:0] word_o
);

  // The same word sits in every lane; the mask decides which lane the MIG actually writes.
  assign wdf_data_o = {LANES{wd_i}};

  // Mask bit 1 = byte not written, so only the four bytes of the selected lane are cleared.
  always_comb begin
    wdf_mask_o = '1;
    wdf_mask_o[{lane_i, 2'b00} +: 4] = 4'h0;
  end

  assign word_o = line_i[{lane_i, 5'b00000} +: WORD_W];

endmodule

// File: rtl/ddr2_responder.sv
// Bridges a single-word core request port onto the MIG app interface (128-bit lines).
// Latency: stall rises the cycle after acceptance and falls one cycle after the MIG handshake/read data.
// Backpressure: ddr2_stall blocks new requests; app_rdy/app_wdf_rdy are waited on independently.
// Optional one-line read buffer enabled by macro DDR2_LINE_BUFFER_EN.
module ddr2_responder
  import ddr2_pkg::*;
#(
  parameter int ADDR_W = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ddr2_en,
  input  logic              ddr2_we,
  input  logic [31:0]       ddr2_addr,
  input  logic [31:0]       ddr2_wd,
  output logic [31:0]       ddr2_rd,
  output logic              ddr2_stall,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [127:0]      app_wdf_data,
  output logic [15:0]       app_wdf_mask,
  input  logic              app_wdf_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid
);

  state_t              state_q, state_d;
  logic                stall_q, stall_d;
  logic [WORD_W-1:0]   rd_q, rd_d;
  logic                cmd_done_q, cmd_done_d;
  logic                wdf_done_q, wdf_done_d;
  logic [1:0]          lane_q;
  logic [22:0]         line_q;
  logic [WORD_W-1:0]   wd_q;
  logic                accept;
  logic                req_hit;
  logic [LINE_W-1:0]   sel_line;
  logic [WORD_W-1:0]   sel_word;
  logic [6:0]          unused_addr;

  assign unused_addr = ddr2_addr[31:25];

  // A request is only taken while idle and not in the trailing stall cycle.
  assign accept = ddr2_en && !stall_q && (state_q == IDLE);

`ifdef DDR2_LINE_BUFFER_EN
  logic [LINE_W-1:0] buf_q;
  logic [22:0]       tag_q;
  logic              bvld_q;
  logic              hit_q;
  logic [LINE_W-1:0] merged;

  assign req_hit  = bvld_q && (tag_q == ddr2_addr[24:2]);
  assign sel_line = (state_q == RD_WAIT) ? app_rd_data : buf_q;

  // Buffer line with the pending write lane merged in, byte by byte under the write mask.
  always_comb begin
    merged = buf_q;
    for (int b = 0; b < MASK_W; b++) begin
      if (!app_wdf_mask[b]) merged[8*b +: 8] = app_wdf_data[8*b +: 8];
    end
  end

  // Line buffer: filled by read misses, patched by write hits, invalidated by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q  <= '0;
      tag_q  <= '0;
      bvld_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      hit_q <= accept && req_hit;
      if (state_q == RD_WAIT && app_rd_data_valid) begin
        buf_q  <= app_rd_data;
        tag_q  <= line_q;
        bvld_q <= 1'b1;
      end else if (state_q == WR && hit_q) begin
        buf_q <= merged;
      end
    end
  end
`else
  assign req_hit  = 1'b0;
  assign sel_line = app_rd_data;
`endif

  ddr2_lane_mux u_lane_mux (
    .lane_i     (lane_q),
    .wd_i       (wd_q),
    .line_i     (sel_line),
    .wdf_data_o (app_wdf_data),
    .wdf_mask_o (app_wdf_mask),
    .word_o     (sel_word)
  );

  assign app_addr    = ADDR_W'({line_q, 4'b0000});
  assign app_wdf_end = app_wdf_wren;
  assign ddr2_rd     = rd_q;
  assign ddr2_stall  = stall_q;

  // Stall covers every non-idle cycle plus one trailing cycle so the result is settled when it drops.
  assign stall_d = accept || (state_q != IDLE);

  // Next-state and MIG strobes; write command and data beat are retired independently.
  always_comb begin
    state_d      = state_q;
    cmd_done_d   = cmd_done_q;
    wdf_done_d   = wdf_done_q;
    rd_d         = rd_q;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_cmd      = CMD_RD;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          if (ddr2_we)       state_d = WR;
          else if (!req_hit) state_d = RD_CMD;
        end
`ifdef DDR2_LINE_BUFFER_EN
        if (hit_q) rd_d = sel_word;
`endif
      end
      WR: begin
        app_cmd      = CMD_WR;
        app_en       = !cmd_done_q;
        app_wdf_wren = !wdf_done_q;
        cmd_done_d   = cmd_done_q || app_rdy;
        wdf_done_d   = wdf_done_q || app_wdf_rdy;
        if (cmd_done_d && wdf_done_d) begin
          state_d    = IDLE;
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
        end
      end
      RD_CMD: begin
        app_en = 1'b1;
        if (app_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          rd_d    = sel_word;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and captured request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      stall_q    <= 1'b0;
      rd_q       <= '0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
      lane_q     <= '0;
      line_q     <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      rd_q       <= rd_d;
      cmd_done_q <= cmd_done_d;
      wdf_done_q <= wdf_done_d;
      if (accept) begin
        lane_q <= ddr2_addr[1:0];
        line_q <= ddr2_addr[24:2];
        wd_q   <= ddr2_wd;
      end
    end
  end

endmodule

// File: doc/ddr2_responder.md
DDR2_RESPONDER -- requirements
Module: ddr2_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, the MIG app_addr width in bits.
REQ-002 SHALL have port clock, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ddr2_en, input, 1: request strobe from the core.
REQ-005 SHALL have port ddr2_we, input, 1: 1 = write, 0 = read; qualified by ddr2_en.
REQ-006 SHALL have port ddr2_addr, input, 32: word address; only bits [24:0] are used.
REQ-007 SHALL have port ddr2_wd, input, 32: write word.
REQ-008 SHALL have port ddr2_rd, output, 32: read word.
REQ-009 SHALL have port ddr2_stall, output, 1: responder busy.
REQ-010 SHALL have MIG app-side ports: app_en (out, 1), app_cmd (out, 3), app_addr (out, ADDR_W), app_rdy (in, 1), app_wdf_wren (out, 1), app_wdf_end (out, 1), app_wdf_data (out, 128), app_wdf_mask (out, 16), app_wdf_rdy (in, 1), app_rd_data (in, 128), app_rd_data_valid (in, 1).

Function
REQ-011 SHALL accept a request only when ddr2_en=1 and ddr2_stall=0; ddr2_en while stall=1 SHALL be ignored.
REQ-012 SHALL register ddr2_stall; it SHALL rise the cycle after acceptance and stay high until the access completes.
REQ-013 SHALL form app_addr as {ddr2_addr[24:2], 4'b0000} (128-bit line); lane = ddr2_addr[1:0].
REQ-014 SHALL drive app_cmd 3'b000 for write and 3'b001 for read.
REQ-015 SHALL implement FSM states IDLE, WR, RD_CMD and RD_WAIT.
- IDLE: on write go to WR; on read go to RD_CMD, or stay in IDLE on a buffer hit (see Configuration).
REQ-016 In WR, SHALL hold app_en until app_rdy=1 and app_wdf_wren=app_wdf_end=1 until app_wdf_rdy=1, tracking each acceptance independently; the two may be accepted in either order or in the same cycle. SHALL return to IDLE once both are done.
REQ-017 Write data SHALL be ddr2_wd replicated in all 4 lanes; app_wdf_mask SHALL be 0 for bytes 4*lane..4*lane+3 and 1 elsewhere (1 = masked).
REQ-018 In RD_CMD, SHALL hold app_en until app_rdy=1, then go to RD_WAIT.
REQ-019 In RD_WAIT, on app_rd_data_valid=1, SHALL latch app_rd_data[32*lane +: 32] into ddr2_rd and return to IDLE.
REQ-020 ddr2_stall SHALL fall in the cycle after completion; ddr2_rd SHALL be valid when stall is first seen low and SHALL hold until the next read completes.
REQ-021 Writes SHALL not change ddr2_rd.
REQ-022 app_rd_data_valid outside RD_WAIT SHALL be ignored.

Reset
REQ-023 reset SHALL force IDLE and ddr2_stall=0, ddr2_rd=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, and SHALL clear the acceptance flags.
REQ-024 reset mid-operation SHALL abandon the access without retry; a MIG response arriving afterwards SHALL be discarded.

Configuration
REQ-025 With macro DDR2_LINE_BUFFER_EN defined, SHALL keep one 128-bit line, its tag (addr[24:2]) and a valid bit, cleared by reset.
- A read whose tag matches a valid buffer SHALL hold stall high for exactly 1 cycle and return the lane with no MIG command.
- A read miss SHALL fill the buffer from app_rd_data.
- A write SHALL go to the MIG in all cases; on a tag hit it SHALL also update the buffer lane.
REQ-026 Without the macro, every read SHALL go through RD_CMD/RD_WAIT, and no buffer storage SHALL exist.

Structure
REQ-027 Package ddr2_pkg SHALL hold the FSM state enum, the app_cmd constants CMD_WR/CMD_RD, and the line-width constants (LINE_W=128, LANES=4).
REQ-028 Lane select, replicate and mask generation SHALL be a sub-module ddr2_lane_mux; the FSM SHALL stay in ddr2_responder.

Verification
REQ-029 Write addr=0x10, wd=0xDEADBEEF, app_rdy and app_wdf_rdy tied 1 -> one app_en pulse, app_addr=0x40, mask=0xFFF0, data=4x 0xDEADBEEF; stall high exactly 2 cycles.
REQ-030 Read addr=0x13, app_rd_data lane 3 = 0x12345678 after 5 cycles -> ddr2_rd=0x12345678 when stall falls; app_cmd=001.
REQ-031 Write with app_wdf_rdy=1 and app_rdy delayed 3 cycles -> exactly one wdf beat and one command; stall holds until both are accepted.
REQ-032 ddr2_en pulsed during stall -> no second MIG command; the outstanding request completes normally.
REQ-033 reset asserted in RD_WAIT, then late app_rd_data_valid -> ddr2_rd stays 0, FSM in IDLE, stall 0.
REQ-034 With DDR2_LINE_BUFFER_EN: read 0x20 (miss), write 0x21=0xA5A5A5A5, read 0x21 -> second read hits: stall high 1 cycle, no app_en, ddr2_rd=0xA5A5A5A5.
